// File: rtl/pc_ras_unit.sv
// Fetch-stage program counter with branch/jump/JR selection, late redirect and a
// circular return-address stack that predicts returns.
module pc_ras_unit #(
    parameter int unsigned WIDTH     = 32,
    parameter logic [WIDTH-1:0] PC_INIT = '0,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              pcEN,
    input  logic [2:0]        pc_src,
    input  logic [15:0]       imm16,
    input  logic [25:0]       imm26,
    input  logic [WIDTH-1:0]  jr_target,
    input  logic              redirect_en,
    input  logic [WIDTH-1:0]  redirect_addr,
    output logic [WIDTH-1:0]  imemaddr,
    output logic [WIDTH-1:0]  npc,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ras_underflow
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    localparam logic [2:0] SRC_BR  = 3'd1;
    localparam logic [2:0] SRC_J   = 3'd2;
    localparam logic [2:0] SRC_JR  = 3'd3;
    localparam logic [2:0] SRC_JAL = 3'd4;
    localparam logic [2:0] SRC_RET = 3'd5;

    logic [WIDTH-1:0] pc, pc_nxt;
    logic [WIDTH-1:0] ras [RAS_DEPTH];
    logic [PTR_W-1:0] tp, tp_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             uf_nxt;
    logic             push;

    logic [WIDTH-1:0] seq_tgt, br_tgt, jmp_tgt, jr_tgt, redir_tgt, br_off;

    // Candidate targets; masking keeps all input bits live while word-aligning.
    always_comb begin
        seq_tgt   = pc + WIDTH'(4);
        br_off    = {{(WIDTH-18){imm16[15]}}, imm16, 2'b00};
        br_tgt    = seq_tgt + br_off;
        jmp_tgt   = (seq_tgt & ~WIDTH'(28'hFFF_FFFF)) | WIDTH'({imm26, 2'b00});
        jr_tgt    = jr_target & ~WIDTH'(3);
        redir_tgt = redirect_addr & ~WIDTH'(3);
    end

    assign imemaddr  = pc;
    assign npc       = seq_tgt;
    assign ras_empty = (cnt == '0);
    assign ras_full  = (cnt == CNT_W'(RAS_DEPTH));

    // Next-state selection: redirect beats stall, stall beats pc_src.
    always_comb begin
        pc_nxt  = pc;
        tp_nxt  = tp;
        cnt_nxt = cnt;
        uf_nxt  = 1'b0;
        push    = 1'b0;
        if (redirect_en) begin
            pc_nxt = redir_tgt;
        end else if (pcEN) begin
            case (pc_src)
                SRC_BR:  pc_nxt = br_tgt;
                SRC_J:   pc_nxt = jmp_tgt;
                SRC_JR:  pc_nxt = jr_tgt;
                SRC_JAL: begin
                    pc_nxt = jmp_tgt;
                    push   = 1'b1;
                    tp_nxt = tp + PTR_W'(1);
                    if (!ras_full) begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                SRC_RET: begin
                    if (!ras_empty) begin
                        pc_nxt  = ras[tp];
                        tp_nxt  = tp - PTR_W'(1);
                        cnt_nxt = cnt - CNT_W'(1);
                    end else begin
                        pc_nxt = jr_tgt;
                        uf_nxt = 1'b1;
                    end
                end
                default: pc_nxt = seq_tgt;
            endcase
        end
    end

    // A push into a full stack lands on the oldest slot and overwrites it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc            <= PC_INIT;
            tp            <= '0;
            cnt           <= '0;
            ras_underflow <= 1'b0;
            ras           <= '{default: '0};
        end else begin
            pc            <= pc_nxt;
            tp            <= tp_nxt;
            cnt           <= cnt_nxt;
            ras_underflow <= uf_nxt;
            if (push) begin
                ras[tp_nxt] <= seq_tgt;
            end
        end
    end

endmodule

// File: tb/tb_pc_ras_unit.sv
// Scoreboard bench for pc_ras_unit: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_pc_ras_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        pcEN = 1'b0;
    logic [2:0]  pc_src = 3'd0;
    logic [15:0] imm16 = '0;
    logic [25:0] imm26 = '0;
    logic [31:0] jr_target = '0;
    logic        redirect_en = 1'b0;
    logic [31:0] redirect_addr = '0;
    logic [31:0] imemaddr, npc;
    logic        ras_empty, ras_full, ras_underflow;

    pc_ras_unit #(.WIDTH(32), .PC_INIT(32'h0000_0040), .RAS_DEPTH(4)) dut (
        .CLK(CLK), .RST(RST), .pcEN(pcEN), .pc_src(pc_src), .imm16(imm16),
        .imm26(imm26), .jr_target(jr_target), .redirect_en(redirect_en),
        .redirect_addr(redirect_addr), .imemaddr(imemaddr), .npc(npc),
        .ras_empty(ras_empty), .ras_full(ras_full), .ras_underflow(ras_underflow)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int unsigned due;
        string       name;
        logic [31:0] pc;
        logic        empty;
        logic        full;
        logic        uf;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          n_assert = 0;
    int          n_fail = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
        end
    endtask

    // Monitor: compare every expectation that falls due this cycle.
    always @(negedge CLK) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.name, "imemaddr", imemaddr, e.pc);
            chk(e.name, "npc", npc, e.pc + 32'd4);
            chk(e.name, "ras_empty", 32'(ras_empty), 32'(e.empty));
            chk(e.name, "ras_full", 32'(ras_full), 32'(e.full));
            chk(e.name, "ras_underflow", 32'(ras_underflow), 32'(e.uf));
        end
    end

    task automatic expect_at(input int unsigned due, input string nm, input logic [31:0] epc,
                             input logic ee, input logic ef, input logic eu);
        exp_t e;
        e.due = due; e.name = nm; e.pc = epc; e.empty = ee; e.full = ef; e.uf = eu;
        sb.push_back(e);
    endtask

    // Apply one cycle of inputs; the result is visible after the next rising edge.
    task automatic step(input string nm, input logic en, input logic [2:0] src,
                        input logic [15:0] i16, input logic [25:0] i26, input logic [31:0] jrt,
                        input logic rd, input logic [31:0] ra, input logic [31:0] epc,
                        input logic ee, input logic ef, input logic eu);
        pcEN = en; pc_src = src; imm16 = i16; imm26 = i26; jr_target = jrt;
        redirect_en = rd; redirect_addr = ra;
        expect_at(cyc + 1, nm, epc, ee, ef, eu);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        @(posedge CLK); #1;
        expect_at(cyc, "reset", 32'h40, 1'b1, 1'b0, 1'b0);
        @(posedge CLK); #1;
        RST = 1'b0;

        //    name       en    src  imm16     imm26        jr_target     rd    redirect      exp pc        emp  full uf
        step("seq1",     1'b1, 3'd0, 16'h0,   26'h0,       32'h0,        1'b0, 32'h0,        32'h44,       1, 0, 0);
        step("seq2",     1'b1, 3'd0, 16'h0,   26'h0,       32'h0,        1'b0, 32'h0,        32'h48,       1, 0, 0);
        step("seq3",     1'b1, 3'd0, 16'h0,   26'h0,       32'h0,        1'b0, 32'h0,        32'h4C,       1, 0, 0);
        step("redir100", 1'b1, 3'd0, 16'h0,   26'h0,       32'h0,        1'b1, 32'h100,      32'h100,      1, 0, 0);
        step("br_neg",   1'b1, 3'd1, 16'hFFFE,26'h0,       32'h0,        1'b0, 32'h0,        32'h0FC,      1, 0, 0);
        step("redir100b",1'b1, 3'd0, 16'h0,   26'h0,       32'h0,        1'b1, 32'h100,      32'h100,      1, 0, 0);
        step("br_pos",   1'b1, 3'd1, 16'h0003,26'h0,       32'h0,        1'b0, 32'h0,        32'h110,      1, 0, 0);
        step("redir100c",1'b1, 3'd0, 16'h0,   26'h0,       32'h0,        1'b1, 32'h100,      32'h100,      1, 0, 0);
        step("br_stall", 1'b0, 3'd1, 16'h0003,26'h0,       32'h0,        1'b0, 32'h0,        32'h100,      1, 0, 0);
        step("redir3k",  1'b1, 3'd0, 16'h0,   26'h0,       32'h0,        1'b1, 32'h3000_0010,32'h3000_0010,1, 0, 0);
        step("jal",      1'b1, 3'd4, 16'h0,   26'h40,      32'h0,        1'b0, 32'h0,        32'h3000_0100,0, 0, 0);
        step("ret",      1'b1, 3'd5, 16'h0,   26'h0,       32'hDEAD,     1'b0, 32'h0,        32'h3000_0014,1, 0, 0);
        step("jr",       1'b1, 3'd3, 16'h0,   26'h0,       32'h1237,     1'b0, 32'h0,        32'h1234,     1, 0, 0);
        step("j_max",    1'b1, 3'd2, 16'h0,   26'h3FF_FFFF,32'h0,        1'b0, 32'h0,        32'h0FFF_FFFC,1, 0, 0);
        step("jal1",     1'b1, 3'd4, 16'h0,   26'h10,      32'h0,        1'b0, 32'h0,        32'h1000_0040,0, 0, 0);
        step("jal2",     1'b1, 3'd4, 16'h0,   26'h20,      32'h0,        1'b0, 32'h0,        32'h1000_0080,0, 0, 0);
        step("jal3",     1'b1, 3'd4, 16'h0,   26'h30,      32'h0,        1'b0, 32'h0,        32'h1000_00C0,0, 0, 0);
        step("jal4",     1'b1, 3'd4, 16'h0,   26'h40,      32'h0,        1'b0, 32'h0,        32'h1000_0100,0, 1, 0);
        step("jal5",     1'b1, 3'd4, 16'h0,   26'h50,      32'h0,        1'b0, 32'h0,        32'h1000_0140,0, 1, 0);
        step("ret_stall",1'b0, 3'd5, 16'h0,   26'h0,       32'h0,        1'b0, 32'h0,        32'h1000_0140,0, 1, 0);
        step("redir_pri",1'b0, 3'd5, 16'h0,   26'h0,       32'h0,        1'b1, 32'h0000_0807,32'h0000_0804,0, 1, 0);
        step("ret1",     1'b1, 3'd5, 16'h0,   26'h0,       32'h0,        1'b0, 32'h0,        32'h1000_0104,0, 0, 0);
        step("ret2",     1'b1, 3'd5, 16'h0,   26'h0,       32'h0,        1'b0, 32'h0,        32'h1000_00C4,0, 0, 0);
        step("ret3",     1'b1, 3'd5, 16'h0,   26'h0,       32'h0,        1'b0, 32'h0,        32'h1000_0084,0, 0, 0);
        step("ret4",     1'b1, 3'd5, 16'h0,   26'h0,       32'h0,        1'b0, 32'h0,        32'h1000_0044,1, 0, 0);
        step("ret_uf",   1'b1, 3'd5, 16'h0,   26'h0,       32'h200,      1'b0, 32'h0,        32'h200,      1, 0, 1);
        step("seq_after",1'b1, 3'd0, 16'h0,   26'h0,       32'h0,        1'b0, 32'h0,        32'h204,      1, 0, 0);
        step("ret_uf2",  1'b1, 3'd5, 16'h0,   26'h0,       32'h303,      1'b0, 32'h0,        32'h300,      1, 0, 1);
        step("ret_uf3",  1'b1, 3'd5, 16'h0,   26'h0,       32'h400,      1'b0, 32'h0,        32'h400,      1, 0, 1);
        step("uf_stall", 1'b0, 3'd5, 16'h0,   26'h0,       32'h0,        1'b0, 32'h0,        32'h400,      1, 0, 0);
        step("src6_seq", 1'b1, 3'd6, 16'h0,   26'h0,       32'h0,        1'b0, 32'h0,        32'h404,      1, 0, 0);
        step("jal_pre",  1'b1, 3'd4, 16'h0,   26'h8,       32'h0,        1'b0, 32'h0,        32'h20,       0, 0, 0);
        step("hold_pre", 1'b0, 3'd0, 16'h0,   26'h0,       32'h0,        1'b0, 32'h0,        32'h20,       0, 0, 0);

        // Short reset pulse away from any clock edge, during a redirect.
        @(negedge CLK); #2;
        redirect_en = 1'b1; redirect_addr = 32'h0000_0900; pcEN = 1'b1;
        RST = 1'b1;
        #1;
        RST = 1'b0;
        redirect_en = 1'b0; pcEN = 1'b0;
        expect_at(cyc + 1, "async_rst", 32'h40, 1'b1, 1'b0, 1'b0);
        @(posedge CLK); #1;
        step("seq_post", 1'b1, 3'd0, 16'h0,   26'h0,       32'h0,        1'b0, 32'h0,        32'h44,       1, 0, 0);

        repeat (2) @(negedge CLK);
        #1;
        n_assert++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
